booth_op_sequencer: RTL and testbench

Front-end controller that sits directly upstream of the Booth multiplier datapath/controller. Accepts signed operand pairs on a valid/ready stream, generates the multiplier's clear, operand-load and partial-product-load strobes in the required order, waits a fixed iteration window, then captures the 2·WIDTH product and presents it on a valid/ready result stream. One multiplication is in flight at a time.

---
 rtl/booth_op_sequencer.sv | 137 +++++++++++++
 tb/tb_booth_op_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/booth_op_sequencer.sv
// Operand/strobe sequencer in front of a Booth multiplier: accept, clear, load, load-PP, settle, capture, hand off.
// Optional build macro BOOTH_SEQ_CHECK_EN adds chk_err, a signed-product cross-check taken at capture.
module booth_op_sequencer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_a,
  input  logic [WIDTH-1:0]     s_b,
  output logic [WIDTH-1:0]     mul_in_A,
  output logic [WIDTH-1:0]     mul_in_B,
  output logic                 mul_reset,
  output logic                 mul_ld,
  output logic                 mul_ld_PP,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*WIDTH-1:0]   m_product,
  output logic                 busy,
  output logic [2:0]           dbg_state
`ifdef BOOTH_SEQ_CHECK_EN
  ,
  output logic                 chk_err
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid must hold with stable payload until then, and ready never depends
  // combinationally on valid (every output here is a register).

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_GAP,
    ST_LDPP,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;

  assign dbg_state = state;

`ifdef BOOTH_SEQ_CHECK_EN
  logic signed [2*WIDTH-1:0] ref_product;
  assign ref_product = $signed(mul_in_A) * $signed(mul_in_B);
`endif

  // Strobes are set on the edge entering their state so each is a clean one-cycle register pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      s_ready   <= 1'b1;
      busy      <= 1'b0;
      mul_in_A  <= '0;
      mul_in_B  <= '0;
      mul_reset <= 1'b0;
      mul_ld    <= 1'b0;
      mul_ld_PP <= 1'b0;
      m_valid   <= 1'b0;
      m_product <= '0;
      cnt       <= '0;
`ifdef BOOTH_SEQ_CHECK_EN
      chk_err   <= 1'b0;
`endif
    end else begin
      mul_reset <= 1'b0;
      mul_ld    <= 1'b0;
      mul_ld_PP <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_valid && s_ready) begin
            mul_in_A  <= s_a;
            mul_in_B  <= s_b;
            s_ready   <= 1'b0;
            busy      <= 1'b1;
            mul_reset <= 1'b1;
            state     <= ST_CLR;
          end
        end
        ST_CLR: begin
          mul_ld <= 1'b1;
          state  <= ST_LOAD;
        end
        ST_LOAD: begin
          state <= ST_GAP;
        end
        ST_GAP: begin
          mul_ld_PP <= 1'b1;
          state     <= ST_LDPP;
        end
        ST_LDPP: begin
          cnt   <= CNT_INIT;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // The counter reads 0 in the last of SETTLE_CYCLES wait cycles.
          if (cnt == 8'd0) begin
            m_product <= mul_product;
            m_valid   <= 1'b1;
`ifdef BOOTH_SEQ_CHECK_EN
            chk_err   <= (mul_product != ref_product);
`endif
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_DONE: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
`ifdef BOOTH_SEQ_CHECK_EN
            chk_err <= 1'b0;
`endif
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b1;
          busy    <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Bench for booth_op_sequencer: behavioural multiplier stub, signed-product model, per-cycle strobe timing checks.
module tb_booth_op_sequencer;
  localparam int W  = 16;
  localparam int S  = 18;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_a = '0;
  logic [W-1:0]  s_b = '0;
  logic [W-1:0]  mul_in_A, mul_in_B;
  logic          mul_reset, mul_ld, mul_ld_PP;
  logic [PW-1:0] mul_product;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [PW-1:0] m_product;
  logic          busy;
  logic [2:0]    dbg_state;
`ifdef BOOTH_SEQ_CHECK_EN
  logic          chk_err;
`endif

  booth_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .mul_in_A(mul_in_A), .mul_in_B(mul_in_B),
    .mul_reset(mul_reset), .mul_ld(mul_ld), .mul_ld_PP(mul_ld_PP),
    .mul_product(mul_product),
    .m_valid(m_valid), .m_ready(m_ready), .m_product(m_product),
    .busy(busy), .dbg_state(dbg_state)
`ifdef BOOTH_SEQ_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiplier stub ----------------
  // Product is only correct from the last settle cycle onward; earlier it reads inverted.
  logic signed [W-1:0]  stub_a = '0, stub_b = '0;
  logic signed [PW-1:0] stub_p;
  int                   stub_cnt = 0;
  assign stub_p      = stub_a * stub_b;
  assign mul_product = (stub_cnt >= S) ? stub_p : ~stub_p;

  always @(posedge clk) begin
    if (mul_ld) begin
      stub_a <= mul_in_A;
      stub_b <= mul_in_B;
    end
    if (mul_reset)      stub_cnt <= 0;
    else if (mul_ld_PP) stub_cnt <= 1;
    else if (stub_cnt > 0) stub_cnt <= stub_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return PW'(sa * sb);
  endfunction

  task automatic check_reset_values(input string tag);
    check(tag, {mul_in_A, mul_in_B, m_product}, '0);
    check({tag, "_ctl"}, {m_valid, mul_ld, mul_ld_PP, busy, s_ready, mul_reset}, 6'b000010);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a negedge; presents the pair and returns in the first cycle after acceptance.
  task automatic wait_accept(input logic [W-1:0] a, input logic [W-1:0] b, output bit acc);
    s_a = a;
    s_b = b;
    s_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      if (s_ready) acc = 1'b1;
      @(negedge clk);
    end
    check("accept", acc, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall, output int rise_cyc);
    logic [PW-1:0] exp;
    bit acc;
    exp_q.push_back(model_product(a, b));
    rise_cyc = -1;
    wait_accept(a, b, acc);
    if (!acc) return;
    for (int j = 1; j < 5 + S; j++) begin
      check("strobes", {mul_reset, mul_ld, mul_ld_PP, m_valid, s_ready, busy},
            {j == 1, j == 2, j == 4, 1'b0, 1'b0, 1'b1});
      if (j == 1) check("operands", {mul_in_A, mul_in_B}, {a, b});
      @(negedge clk);
    end
    rise_cyc = cyc;
    exp = exp_q.pop_front();
    check("valid_rise", {mul_reset, mul_ld, mul_ld_PP, m_valid, s_ready, busy}, 6'b000101);
    check("product", m_product, exp);
`ifdef BOOTH_SEQ_CHECK_EN
    check("chk_err", chk_err, 1'b0);
`endif
    if (stall > 0) begin
      m_ready = 1'b0;
      s_a = ~a;
      s_b = ~b;
      s_valid = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_ctl", {m_valid, s_ready, busy}, 3'b101);
        check("stall_product", m_product, exp);
        check("stall_operands", {mul_in_A, mul_in_B}, {a, b});
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("handshake", {m_valid, s_ready, busy}, 3'b010);
  endtask

  task automatic abort_in_wait();
    bit acc;
    int seen;
    wait_accept(16'h0ABC, 16'h0123, acc);
    if (!acc) return;
    repeat (7) @(negedge clk);
    check("abort_pre", {busy, s_ready, m_valid}, 3'b100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("abort_reset");
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (m_valid || busy) seen++;
    end
    check("no_stale_result", seen, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r;
    int rise[4];
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {s_ready, busy}, 2'b10);

    run_op(16'd3, 16'd5, 0, r);
    run_op(16'hFFFE, 16'd7, 0, r);
    run_op(16'h8000, 16'h8000, 0, r);
    run_op(16'h7FFF, 16'h8000, 0, r);
    run_op(W'($urandom()), W'($urandom()), 10, r);

    abort_in_wait();
    run_op(16'h1234, 16'hFEDC, 0, r);

    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom()), W'($urandom()), 0, rise[i]);
      if (i > 0) check("b2b_spacing", rise[i] - rise[i-1], 6 + S);
    end

    for (int i = 0; i < 6; i++)
      run_op(W'($urandom()), W'($urandom()), $urandom_range(0, 3), r);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
